// File: rtl/prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module      : prog_clk_divider
// Description : Programmable 50% duty clock divider. It takes a half-period
//               code through a one-entry pending slot, and the code becomes
//               active at a period boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_clk_divider #(
  parameter int CNT_W        = 8,
  parameter int DEFAULT_HALF = 249
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             div_clk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] cur_half,
  output logic             running
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_default_half = CNT_W'(DEFAULT_HALF);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cur_half_q, cur_half_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               div_clk_q, div_clk_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               cfg_ready_q;
  logic               running_q;

  logic               w_at_end;
  logic               w_accept;
  logic               w_apply;

  assign w_at_end = (cnt_q == cur_half_q);
  assign w_accept = cfg_valid && cfg_ready_q;
  // A pending code takes effect only when a new high phase begins after a
  // low phase, or at once while idle, so a running period is never reshaped.
  assign w_apply  = pend_vld_q &&
                    ((state_q == IDLE) || ((state_q == LOW) && w_at_end && en));

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    div_clk_d = 1'b0;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d   = HIGH;
          div_clk_d = 1'b1;
          rise_d    = 1'b1;
        end
      end
      HIGH: begin
        if (w_at_end) begin
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          div_clk_d = 1'b1;
        end
      end
      LOW: begin
        if (w_at_end) begin
          if (en) begin
            state_d   = HIGH;
            div_clk_d = 1'b1;
            rise_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cur_half_d = cur_half_q;
    if (w_apply) begin
      cur_half_d = pend_q;
      pend_vld_d = 1'b0;
    end
    // Acceptance requires an empty slot, so it never collides with an apply.
    if (w_accept) begin
      pend_d     = cfg_half;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_half_q  <= c_default_half;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      div_clk_q   <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_half_q  <= cur_half_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      div_clk_q   <= div_clk_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      cfg_ready_q <= !pend_vld_d;
      running_q   <= (state_d != IDLE);
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign div_clk   = div_clk_q;
  assign rise_stb  = rise_q;
  assign fall_stb  = fall_q;
  assign cur_half  = cur_half_q;
  assign running   = running_q;

endmodule
`default_nettype wire

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the half-period counter and configuration word.
REQ-002 SHALL have parameter DEFAULT_HALF, default 249, reset half-period code; 249 gives 200 kHz from a 100 MHz clock.
REQ-003 SHALL have port clk_100MHz, input, 1 bit, the single system clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port en, input, 1 bit, run request for the divided clock.
REQ-006 SHALL have port cfg_valid, input, 1 bit, new half-period code offered.
REQ-007 SHALL have port cfg_half, input, CNT_W bits, half-period code N; high and low phases each last N+1 cycles.
REQ-008 SHALL have port cfg_ready, output, 1 bit, pending slot empty; a code is accepted on cfg_valid && cfg_ready.
REQ-009 SHALL have port div_clk, output, 1 bit, registered divided clock, 50% duty.
REQ-010 SHALL have port rise_stb, output, 1 bit, one-cycle strobe, high in the first cycle div_clk is 1.
REQ-011 SHALL have port fall_stb, output, 1 bit, one-cycle strobe, high in the first cycle div_clk is 0 after a high phase.
REQ-012 SHALL have port cur_half, output, CNT_W bits, half-period code currently in effect.
REQ-013 SHALL have port running, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, HIGH and LOW; div_clk is 1 only in HIGH.
REQ-015 SHALL leave IDLE for HIGH on the first edge with en=1, setting div_clk=1, rise_stb=1 and counter=0.
REQ-016 SHALL, in HIGH, increment the counter each cycle; on counter==cur_half it SHALL go to LOW with div_clk=0, fall_stb=1 and counter=0.
REQ-017 SHALL, in LOW, on counter==cur_half go to HIGH with rise_stb=1 if en=1, otherwise to IDLE with no strobe.
REQ-018 SHALL ignore en deassertion mid-period; the current period always completes (no runt pulses).
REQ-019 SHALL give period 2*(cur_half+1) cycles; cur_half=0 gives divide-by-2 with div_clk toggling every cycle.
REQ-020 SHALL hold an accepted code in a one-entry pending register; cfg_ready SHALL be 0 while that register is full.
REQ-021 SHALL copy the pending code to cur_half only at a LOW-to-HIGH boundary, or on the next edge when in IDLE; this frees the slot.
REQ-022 SHALL, when acceptance and a boundary coincide, apply the previously pending code (if any) at that boundary; the newly accepted code waits for the next boundary.
REQ-023 SHALL keep the counter in CNT_W bits; the counter SHALL never exceed cur_half, so no wrap-around occurs.
REQ-024 SHALL assert rise_stb and fall_stb for exactly one cycle each, never together, and never in IDLE.
REQ-025 SHALL ignore cfg_half while cfg_valid=0 or cfg_ready=0.
REQ-026 SHALL produce all outputs directly from flops, with no combinational path from any input to any output.

Reset
REQ-027 SHALL, on rst_n=0 and regardless of clock, force state=IDLE, div_clk=0, rise_stb=0, fall_stb=0, counter=0, cur_half=DEFAULT_HALF, pending empty, cfg_ready=1 and running=0.
REQ-028 SHALL, on reset mid-period, drop div_clk immediately; after release it SHALL restart from IDLE with DEFAULT_HALF, and any pending code SHALL be discarded.
REQ-029 SHALL, if en=1 at the first edge after rst_n rises, start HIGH on that edge.

Verification
REQ-030 SHALL check: reset, then en=1 with defaults -> div_clk high 250 cycles, low 250 cycles, period 500; rise_stb/fall_stb each one cycle per period.
REQ-031 SHALL check: cfg_half=3 accepted in the middle of a HIGH phase with cur_half=9 -> current period stays 20 cycles; the next period is 8 cycles; cur_half changes at the rise.
REQ-032 SHALL check: a second cfg_valid while the slot is full -> cfg_ready=0 and the code is ignored; the first code is applied; cfg_ready returns to 1 on the boundary cycle.
REQ-033 SHALL check: en dropped 2 cycles into HIGH with cur_half=4 -> the full 10-cycle period completes; then IDLE, div_clk=0, running=0, no extra rise_stb.
REQ-034 SHALL check: cfg_half=0 with en=1 -> div_clk toggles every cycle, and rise_stb and fall_stb alternate every cycle.
REQ-035 SHALL check: rst_n pulsed low mid-LOW with a code pending -> all outputs reset asynchronously; after release cur_half=249 and the pending code is lost.
